// File: rtl/nonce_hub_arb.sv
// nonce_hub_arb: result hub for the mining cluster.
// Each slave has a capture register and a pending flag. A round-robin arbiter
// moves pending results into a circular FIFO, one per cycle. A small TX FSM
// hands the FIFO head to serial_transmit one word at a time.
// A result is lost only when a pending capture is overwritten before it is
// granted. Such losses are counted in a saturating counter.
// Optional feature macro: NONCE_HUB_DEDUP_EN. When it is defined, a granted
// nonce that equals the last nonce written to the FIFO is discarded.
// Handshake: serial_send is a one-cycle request, and golden_nonce/golden_slave
// are valid from that cycle until the next request. serial_busy=1 means the
// transmitter owns the word. The FSM waits for busy to rise and then fall
// before it offers the next word.
module nonce_hub_arb #(
  parameter int SLAVES = 3,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int SID_W  = 4
) (
  input  logic                    uart_clk,
  input  logic                    reset,
  input  logic [SLAVES-1:0]       new_nonces,
  input  logic [SLAVES*32-1:0]    slave_nonces,
  input  logic                    serial_busy,
  output logic                    serial_send,
  output logic [31:0]             golden_nonce,
  output logic [SID_W-1:0]        golden_slave,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    fifo_full,
  output logic [CNT_W-1:0]        overwrite_count,
  output logic [1:0]              tx_state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = SID_W + 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

  // capture stage
  logic [31:0]       hold_q [SLAVES];
  logic [SLAVES-1:0] pending_q, pending_d;
  logic [SLAVES-1:0] ovw_hit;
  logic [SID_W-1:0]  rr_q;
  logic [CNT_W-1:0]  ovw_cnt_q, ovw_cnt_d;

  // arbiter
  logic              grant_vld;
  logic [SID_W-1:0]  grant_idx;
  logic [31:0]       grant_nonce;
  logic [SLAVES-1:0] grant_oh;
  logic              dup;
  logic              push;

  // fifo
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;
  logic              full_w;
  logic              pop;

  // tx fsm
  tx_state_e         state_q;
  logic              send_q;
  logic [31:0]       gnonce_q;
  logic [SID_W-1:0]  gslave_q;

  assign full_w = (level_q == (AW+1)'(DEPTH));

  // Round-robin search: first pending slave above rr_q, with wrap. A full FIFO blocks the search.
  always_comb begin
    grant_vld   = 1'b0;
    grant_idx   = '0;
    grant_nonce = '0;
    for (int k = 1; k <= SLAVES; k++) begin
      for (int j = 0; j < SLAVES; j++) begin
        if (!grant_vld && !full_w && pending_q[j] &&
            (j == ((int'(rr_q) + k) % SLAVES))) begin
          grant_vld   = 1'b1;
          grant_idx   = SID_W'(j);
          grant_nonce = hold_q[j];
        end
      end
    end
  end

  // Per-slave grant decode, next pending flags and lost-result detection.
  always_comb begin
    grant_oh  = '0;
    pending_d = '0;
    ovw_hit   = '0;
    for (int i = 0; i < SLAVES; i++) begin
      grant_oh[i]  = grant_vld && (grant_idx == SID_W'(i));
      pending_d[i] = new_nonces[i] | (pending_q[i] & ~grant_oh[i]);
      ovw_hit[i]   = new_nonces[i] & pending_q[i] & ~grant_oh[i];
    end
  end

  // Saturating overwrite counter; several lanes may lose a result in the same cycle.
  always_comb begin
    ovw_cnt_d = ovw_cnt_q;
    for (int i = 0; i < SLAVES; i++) begin
      if (ovw_hit[i] && (ovw_cnt_d != '1)) ovw_cnt_d = ovw_cnt_d + CNT_W'(1);
    end
  end

`ifdef NONCE_HUB_DEDUP_EN
  logic [31:0] last_q;
  logic        last_vld_q;

  assign dup = last_vld_q && (last_q == grant_nonce);

  // Remember the last nonce actually written to the FIFO.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (push) begin
      last_q     <= grant_nonce;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // A discarded duplicate still consumes the grant. Only the FIFO write is skipped.
  assign push = grant_vld & ~dup;

  // Capture registers, pending flags, RR pointer and overwrite count.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SLAVES; i++) hold_q[i] <= '0;
      pending_q <= '0;
      rr_q      <= SID_W'(SLAVES - 1);
      ovw_cnt_q <= '0;
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (new_nonces[i]) hold_q[i] <= slave_nonces[i*32 +: 32];
      end
      pending_q <= pending_d;
      ovw_cnt_q <= ovw_cnt_d;
      if (grant_vld) rr_q <= grant_idx;
    end
  end

  // The head is popped only by the TX FSM in IDLE while the transmitter is free.
  assign pop = (state_q == ST_IDLE) && (level_q != '0) && !serial_busy;

  // Level tracking; push and pop in the same cycle leave the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage: {slave index, nonce}. The contents are don't-care until written.
  always_ff @(posedge uart_clk) begin
    if (push) mem_q[wr_ptr_q] <= {grant_idx, grant_nonce};
  end

  // FIFO pointers and level; DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // TX FSM: pop head, pulse send, then follow busy up and back down.
  always_ff @(posedge uart_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      send_q   <= 1'b0;
      gnonce_q <= '0;
      gslave_q <= '0;
    end else begin
      send_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            {gslave_q, gnonce_q} <= mem_q[rd_ptr_q];
            send_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND:      state_q <= ST_WAIT_BUSY;
        ST_WAIT_BUSY: if (serial_busy) state_q <= ST_WAIT_DONE;
        ST_WAIT_DONE: if (!serial_busy) state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  assign serial_send     = send_q;
  assign golden_nonce    = gnonce_q;
  assign golden_slave    = gslave_q;
  assign fifo_level      = level_q;
  assign fifo_full       = full_w;
  assign overwrite_count = ovw_cnt_q;
  assign tx_state_dbg    = state_q;

endmodule

// File: tb/tb_nonce_hub_arb.sv
// Testbench for nonce_hub_arb (SLAVES=3, DEPTH=8).
// Uses a transaction-level scoreboard: the expected queue holds {slave, nonce}
// words in the order they must reach the transmitter.
// Dedup expectations follow NONCE_HUB_DEDUP_EN.
module tb_nonce_hub_arb;

  localparam int SLAVES = 3;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 16;
  localparam int SID_W  = 4;
  localparam int W      = SID_W + 32;
  localparam logic [1:0] TX_IDLE      = 2'd0;
  localparam logic [1:0] TX_WAIT_DONE = 2'd3;

  logic              uart_clk;
  logic              reset;
  logic [SLAVES-1:0] new_nonces;
  logic [SLAVES*32-1:0] slave_nonces;
  logic              serial_busy;
  logic              serial_send;
  logic [31:0]       golden_nonce;
  logic [SID_W-1:0]  golden_slave;
  logic [3:0]        fifo_level;
  logic              fifo_full;
  logic [CNT_W-1:0]  overwrite_count;
  logic [1:0]        tx_state_dbg;

  logic busy_force;
  logic busy_tx;
  int   busy_cnt;
  int   busy_min;
  int   busy_max;
  logic prev_send;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_q[$];

  int checks_total;
  int checks_passed;

  assign serial_busy = busy_force | busy_tx;

  nonce_hub_arb #(
    .SLAVES(SLAVES), .DEPTH(DEPTH), .CNT_W(CNT_W), .SID_W(SID_W)
  ) dut (
    .uart_clk       (uart_clk),
    .reset          (reset),
    .new_nonces     (new_nonces),
    .slave_nonces   (slave_nonces),
    .serial_busy    (serial_busy),
    .serial_send    (serial_send),
    .golden_nonce   (golden_nonce),
    .golden_slave   (golden_slave),
    .fifo_level     (fifo_level),
    .fifo_full      (fifo_full),
    .overwrite_count(overwrite_count),
    .tx_state_dbg   (tx_state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    uart_clk = 1'b0;
    forever #5 uart_clk = ~uart_clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", checks_passed, checks_total);
    $fatal(1, "watchdog");
  end

  // Transmitter model: records each send, then holds busy for busy_min..busy_max cycles.
  initial begin
    busy_tx   = 1'b0;
    busy_cnt  = 0;
    prev_send = 1'b0;
    forever begin
      @(posedge uart_clk);
      #1;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) busy_tx = 1'b0;
      end
      if (serial_send === 1'b1) begin
        rx_q.push_back({golden_slave, golden_nonce});
        checks_total++;
        if (prev_send) $display("FAIL send_one_cycle: serial_send high on two consecutive cycles, required single-cycle pulse");
        else checks_passed++;
        busy_tx  = 1'b1;
        busy_cnt = $urandom_range(busy_max, busy_min);
      end
      prev_send = (serial_send === 1'b1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge uart_clk);
    reset      = 1'b1;
    new_nonces = '0;
    busy_force = 1'b0;
    repeat (2) @(negedge uart_clk);
    reset = 1'b0;
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rx_q.size() >= n) break;
      @(negedge uart_clk);
    end
    if (rx_q.size() >= n) ok = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset        = 1'b1;
    new_nonces   = '0;
    slave_nonces = '0;
    busy_force   = 1'b0;
    busy_min     = 4;
    busy_max     = 4;
    repeat (2) @(negedge uart_clk);
    for (int pass = 0; pass < 2; pass++) begin
      checks_total++;
      if (serial_send !== 1'b0) $display("FAIL rst_send%0d: got %0b want 0", pass, serial_send); else checks_passed++;
      checks_total++;
      if (golden_nonce !== 32'h0) $display("FAIL rst_nonce%0d: got %h want 0", pass, golden_nonce); else checks_passed++;
      checks_total++;
      if (golden_slave !== '0) $display("FAIL rst_slave%0d: got %0d want 0", pass, golden_slave); else checks_passed++;
      checks_total++;
      if (fifo_level !== 4'd0) $display("FAIL rst_level%0d: got %0d want 0", pass, fifo_level); else checks_passed++;
      checks_total++;
      if (fifo_full !== 1'b0) $display("FAIL rst_full%0d: got %0b want 0", pass, fifo_full); else checks_passed++;
      checks_total++;
      if (overwrite_count !== '0) $display("FAIL rst_ovw%0d: got %0d want 0", pass, overwrite_count); else checks_passed++;
      checks_total++;
      if (tx_state_dbg !== TX_IDLE) $display("FAIL rst_state%0d: got %0d want %0d", pass, tx_state_dbg, TX_IDLE); else checks_passed++;
      if (pass == 0) begin
        reset = 1'b0;
        repeat (3) @(negedge uart_clk);
      end
    end
  endtask

  task automatic test_latency();
    bit ok;
    apply_reset();
    busy_min = 4;
    busy_max = 4;
    @(negedge uart_clk);
    new_nonces   = 3'b001;
    slave_nonces = {64'h0, 32'h1234_5678};
    @(posedge uart_clk); #1;
    checks_total++;
    if (serial_send !== 1'b0) $display("FAIL lat_e0_send: got %0b want 0", serial_send); else checks_passed++;
    @(negedge uart_clk);
    new_nonces = '0;
    @(posedge uart_clk); #1;
    checks_total++;
    if (serial_send !== 1'b0) $display("FAIL lat_e1_send: got %0b want 0", serial_send); else checks_passed++;
    checks_total++;
    if (fifo_level !== 4'd1) $display("FAIL lat_e1_level: got %0d want 1", fifo_level); else checks_passed++;
    @(posedge uart_clk); #1;
    checks_total++;
    if (serial_send !== 1'b1) $display("FAIL lat_e2_send: got %0b want 1", serial_send); else checks_passed++;
    checks_total++;
    if (golden_nonce !== 32'h1234_5678) $display("FAIL lat_nonce: got %h want 12345678", golden_nonce); else checks_passed++;
    checks_total++;
    if (golden_slave !== 4'd0) $display("FAIL lat_slave: got %0d want 0", golden_slave); else checks_passed++;
    checks_total++;
    if (fifo_level !== 4'd0) $display("FAIL lat_e2_level: got %0d want 0", fifo_level); else checks_passed++;
    wait_rx(1, 50, ok);
    repeat (10) @(negedge uart_clk);
    checks_total++;
    if (golden_nonce !== 32'h1234_5678) $display("FAIL lat_hold: got %h want 12345678", golden_nonce); else checks_passed++;
  endtask

  task automatic test_three_way();
    bit ok;
    apply_reset();
    busy_min = 20;
    busy_max = 20;
    @(negedge uart_clk);
    new_nonces   = 3'b111;
    slave_nonces = {32'hC, 32'hB, 32'hA};
    exp_q.push_back({4'd0, 32'hA});
    exp_q.push_back({4'd1, 32'hB});
    exp_q.push_back({4'd2, 32'hC});
    @(negedge uart_clk);
    new_nonces = '0;
    wait_rx(3, 300, ok);
    checks_total++;
    if (!ok) $display("FAIL three_count: got %0d words want 3", rx_q.size()); else checks_passed++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks_total++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL three_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); else checks_passed++;
    end
    checks_total++;
    if (overwrite_count !== '0) $display("FAIL three_ovw: got %0d want 0", overwrite_count); else checks_passed++;
  endtask

  task automatic test_fifo_full_stall();
    logic [31:0] n0 [5];
    logic [31:0] n1 [5];
    bit ok;
    apply_reset();
    busy_min   = 3;
    busy_max   = 3;
    busy_force = 1'b1;
    for (int r = 0; r < 5; r++) begin
      n0[r] = 32'h1000_0000 + 32'(r);
      n1[r] = 32'h2000_0000 + 32'(r);
      @(negedge uart_clk);
      new_nonces   = 3'b011;
      slave_nonces = {32'h0, n1[r], n0[r]};
      @(negedge uart_clk);
      new_nonces = '0;
      repeat (1) @(negedge uart_clk);
    end
    // slave 2 reports twice while the FIFO is full: the first result is lost
    @(negedge uart_clk);
    new_nonces   = 3'b100;
    slave_nonces = {32'h1, 64'h0};
    @(negedge uart_clk);
    new_nonces = '0;
    @(negedge uart_clk);
    new_nonces   = 3'b100;
    slave_nonces = {32'h2, 64'h0};
    @(negedge uart_clk);
    new_nonces = '0;
    repeat (5) @(negedge uart_clk);
    checks_total++;
    if (fifo_level !== 4'd8) $display("FAIL full_level: got %0d want 8", fifo_level); else checks_passed++;
    checks_total++;
    if (fifo_full !== 1'b1) $display("FAIL full_flag: got %0b want 1", fifo_full); else checks_passed++;
    checks_total++;
    if (overwrite_count !== 16'd1) $display("FAIL full_ovw: got %0d want 1", overwrite_count); else checks_passed++;
    repeat (20) @(negedge uart_clk);
    checks_total++;
    if (fifo_level !== 4'd8 || rx_q.size() != 0) $display("FAIL full_stall: level %0d sends %0d want 8 and 0", fifo_level, rx_q.size()); else checks_passed++;
    // expected order: four granted rounds, then the stalled slaves in round-robin order after slave 1
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back({4'd0, n0[r]});
      exp_q.push_back({4'd1, n1[r]});
    end
    exp_q.push_back({4'd2, 32'h2});
    exp_q.push_back({4'd0, n0[4]});
    exp_q.push_back({4'd1, n1[4]});
    busy_force = 1'b0;
    wait_rx(11, 600, ok);
    repeat (30) @(negedge uart_clk);
    checks_total++;
    if (!ok || rx_q.size() != 11) $display("FAIL full_count: got %0d words want 11", rx_q.size()); else checks_passed++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks_total++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL full_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); else checks_passed++;
    end
    checks_total++;
    if (fifo_level !== 4'd0) $display("FAIL full_drained: got %0d want 0", fifo_level); else checks_passed++;
  endtask

  task automatic test_dedup();
    int want;
`ifdef NONCE_HUB_DEDUP_EN
    want = 1;
`else
    want = 2;
`endif
    apply_reset();
    busy_min = 4;
    busy_max = 4;
    @(negedge uart_clk);
    new_nonces   = 3'b001;
    slave_nonces = {64'h0, 32'hDEAD_BEEF};
    @(negedge uart_clk);
    new_nonces   = 3'b010;
    slave_nonces = {32'h0, 32'hDEAD_BEEF, 32'h0};
    @(negedge uart_clk);
    new_nonces = '0;
    repeat (60) @(negedge uart_clk);
    checks_total++;
    if (rx_q.size() != want) $display("FAIL dedup_count: got %0d sends want %0d", rx_q.size(), want); else checks_passed++;
    if (rx_q.size() > 0) begin
      checks_total++;
      if (rx_q[0] !== {4'd0, 32'hDEAD_BEEF}) $display("FAIL dedup_word0: got %h want %h", rx_q[0], {4'd0, 32'hDEAD_BEEF}); else checks_passed++;
    end
  endtask

  task automatic test_reset_mid_transfer();
    bit seen;
    apply_reset();
    busy_min = 20;
    busy_max = 20;
    @(negedge uart_clk);
    new_nonces   = 3'b111;
    slave_nonces = {32'h0000_0C03, 32'h0000_0B02, 32'h0000_0A01};
    @(negedge uart_clk);
    new_nonces   = 3'b001;
    slave_nonces = {64'h0, 32'h0000_0A04};
    @(negedge uart_clk);
    new_nonces = '0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (tx_state_dbg === TX_WAIT_DONE) begin
        seen = 1'b1;
        break;
      end
      @(negedge uart_clk);
    end
    checks_total++;
    if (!seen) $display("FAIL mid_reach_wait_done: got state %0d want %0d", tx_state_dbg, TX_WAIT_DONE); else checks_passed++;
    repeat (2) @(negedge uart_clk);
    checks_total++;
    if (fifo_level !== 4'd3) $display("FAIL mid_level_before: got %0d want 3", fifo_level); else checks_passed++;
    rx_q.delete();
    reset = 1'b1;
    #1;
    checks_total++;
    if (serial_send !== 1'b0) $display("FAIL mid_send: got %0b want 0", serial_send); else checks_passed++;
    checks_total++;
    if (fifo_level !== 4'd0) $display("FAIL mid_level: got %0d want 0", fifo_level); else checks_passed++;
    checks_total++;
    if (tx_state_dbg !== TX_IDLE) $display("FAIL mid_state: got %0d want %0d", tx_state_dbg, TX_IDLE); else checks_passed++;
    @(negedge uart_clk);
    reset = 1'b0;
    repeat (40) @(negedge uart_clk);
    checks_total++;
    if (rx_q.size() != 0) $display("FAIL mid_no_send: got %0d sends want 0", rx_q.size()); else checks_passed++;
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] nonce;
    logic [31:0] last_nonce;
    int sid;
    bit ok;
    apply_reset();
    busy_min   = 2;
    busy_max   = 6;
    last_nonce = 32'h0;
    for (int c = 0; c < 400; c++) begin
      @(negedge uart_clk);
      new_nonces = '0;
      if ((exp_q.size() - rx_q.size()) < 5 && $urandom_range(0, 2) != 0) begin
        sid   = $urandom_range(0, SLAVES - 1);
        nonce = $urandom();
        if (nonce == last_nonce) nonce = nonce ^ 32'h1;
        last_nonce   = nonce;
        slave_nonces = {$urandom(), $urandom(), $urandom()};
        slave_nonces[sid*32 +: 32] = nonce;
        new_nonces[sid] = 1'b1;
        exp_q.push_back({4'(sid), nonce});
      end
    end
    @(negedge uart_clk);
    new_nonces = '0;
    wait_rx(exp_q.size(), 2000, ok);
    checks_total++;
    if (!ok) $display("FAIL rand_count: got %0d words want %0d", rx_q.size(), exp_q.size()); else checks_passed++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks_total++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL rand_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); else checks_passed++;
    end
    checks_total++;
    if (overwrite_count !== '0) $display("FAIL rand_ovw: got %0d want 0", overwrite_count); else checks_passed++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks_total  = 0;
    checks_passed = 0;
    test_reset();
    test_latency();
    test_three_way();
    test_fifo_full_stall();
    test_dedup();
    test_reset_mid_transfer();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
